// File: rtl/sa_ctrl_pkg.sv
// Shared definitions for the systolic-array instruction controller:
// instruction field layout, opcodes, state_signal codes and FSM states.
package sa_ctrl_pkg;

    localparam logic [4:0] OP_NOP       = 5'd0;
    localparam logic [4:0] OP_MAC       = 5'd1;
    localparam logic [4:0] OP_SEND_WT   = 5'd2;
    localparam logic [4:0] OP_STORE_OUT = 5'd3;
    localparam logic [4:0] OP_RECV_INP  = 5'd4;
    localparam logic [4:0] OP_RECV_WT   = 5'd5;
    localparam logic [4:0] OP_TX_OUT    = 5'd6;
    localparam logic [4:0] OP_RST_ACC   = 5'd7;

    localparam int OPC_LSB  = 0;
    localparam int OPC_MSB  = 4;
    localparam int ADDR_LSB = 5;
    localparam int ADDR_MSB = 20;
    localparam int DATA_LSB = 21;
    localparam int DATA_MSB = 52;
    localparam int CNT_LSB  = 53;
    localparam int CNT_MSB  = 60;

    // Only the low FIELD_W instruction bits carry information and are queued.
    localparam int FIELD_W      = CNT_MSB + 1;
    localparam int ADDR_FIELD_W = ADDR_MSB - ADDR_LSB + 1;
    localparam int DATA_FIELD_W = DATA_MSB - DATA_LSB + 1;
    localparam int CNT_FIELD_W  = CNT_MSB - CNT_LSB + 1;

    // Beat counter must hold count (up to 255) as well as MAC_CYCLES-1.
    localparam int BEAT_W = 9;

    localparam logic [1:0] SS_IDLE    = 2'b00;
    localparam logic [1:0] SS_LOAD    = 2'b01;
    localparam logic [1:0] SS_COMPUTE = 2'b10;
    localparam logic [1:0] SS_DRAIN   = 2'b11;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_EXEC = 1'b1
    } fsm_state_t;

    // Number of beats an instruction occupies, minus one (terminal count 0).
    function automatic logic [BEAT_W-1:0] beats_minus_one(
        input logic [4:0]             op,
        input logic [CNT_FIELD_W-1:0] cnt,
        input logic [BEAT_W-1:0]      mac_m1,
        input logic [BEAT_W-1:0]      arr_m1
    );
        logic [BEAT_W-1:0] n;
        n = '0;
        case (op)
            OP_MAC:                 n = mac_m1;
            OP_SEND_WT:             n = arr_m1;
            OP_STORE_OUT, OP_TX_OUT: n = {1'b0, cnt};
            default:                n = '0;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/sa_instr_fifo.sv
// Synchronous instruction queue. Push is ignored when full and pop when
// empty; a simultaneous push and pop leaves occupancy unchanged.
module sa_instr_fifo
    import sa_ctrl_pkg::*;
#(
    parameter int WIDTH = FIELD_W,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign rdata   = mem[rd_ptr];

    // Storage array; contents need no reset since the pointers gate visibility.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // Pointer and occupancy tracking; reset flushes the queue.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

endmodule

// File: rtl/sa_controller_v2.sv
// Systolic-array instruction controller: queues instructions and sequences
// each one as a run of registered buffer/array/accumulator strobes.
//
// state  | meaning
// S_IDLE | no instruction held; pops the queue head when one is present
// S_EXEC | holding an instruction; beats_left counts down to its last beat
//
// Outputs are registered one cycle behind the FSM, so the beat held after
// the pop edge appears on the outputs after the following edge.
module sa_controller_v2
    import sa_ctrl_pkg::*;
#(
    parameter int INSTR_W    = 64,
    parameter int ADDR_W     = 14,
    parameter int DATA_W     = 32,
    parameter int OUT_ADDR_W = 4,
    parameter int ARRAY_N    = 4,
    parameter int MAC_CYCLES = 2 * ARRAY_N - 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  instr_valid,
    output logic                  instr_ready,
    input  logic [INSTR_W-1:0]    instruction,
    output logic                  inp_buf_we,
    output logic [ADDR_W-1:0]     inp_buf_addr,
    output logic [DATA_W-1:0]     inp_buf_data,
    output logic                  wt_buf_we,
    output logic [ADDR_W-1:0]     wt_buf_addr,
    output logic [DATA_W-1:0]     wt_buf_data,
    output logic                  wt_send,
    output logic                  mac_en,
    output logic                  acc_result_to_op_buf,
    output logic [OUT_ADDR_W-1:0] acc_to_op_buf_addr,
    output logic                  op_buffer_instr_for_sending_data,
    output logic [OUT_ADDR_W-1:0] out_buf_addr,
    output logic                  instr_for_accum_to_reset,
    output logic [1:0]            state_signal,
    output logic                  i_mode,
    output logic                  busy,
    output logic                  illegal_op
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam logic [BEAT_W-1:0] MAC_M1 = BEAT_W'(MAC_CYCLES - 1);
    localparam logic [BEAT_W-1:0] ARR_M1 = BEAT_W'(ARRAY_N - 1);

    logic                     push;
    logic                     pop;
    logic [FIELD_W-1:0]       fifo_rdata;
    logic                     fifo_full;
    logic                     fifo_empty;
    logic [CNT_W-1:0]         fifo_count;
    logic [CNT_W-1:0]         count_n;

    logic [4:0]               hd_op;
    logic [ADDR_FIELD_W-1:0]  hd_addr;
    logic [DATA_FIELD_W-1:0]  hd_data;
    logic [CNT_FIELD_W-1:0]   hd_cnt;
    logic                     instr_unused;
    logic                     head_unused;

    fsm_state_t               state_q;
    fsm_state_t               state_n;
    logic [4:0]               cur_op;
    logic [4:0]               op_n;
    logic [ADDR_W-1:0]        cur_addr;
    logic [ADDR_W-1:0]        addr_n;
    logic [DATA_W-1:0]        cur_data;
    logic [DATA_W-1:0]        data_n;
    logic [BEAT_W-1:0]        beats_left;
    logic [BEAT_W-1:0]        beats_n;
    logic [OUT_ADDR_W-1:0]    beat_addr;
    logic [OUT_ADDR_W-1:0]    beat_addr_n;
    logic                     last_beat;

    logic                     inp_we_n;
    logic [ADDR_W-1:0]        inp_addr_n;
    logic [DATA_W-1:0]        inp_data_n;
    logic                     wt_we_n;
    logic [ADDR_W-1:0]        wt_addr_n;
    logic [DATA_W-1:0]        wt_data_n;
    logic                     wt_send_n;
    logic                     mac_en_n;
    logic                     acc_n;
    logic [OUT_ADDR_W-1:0]    acc_addr_n;
    logic                     tx_n;
    logic [OUT_ADDR_W-1:0]    out_addr_n;
    logic                     clr_n;
    logic [1:0]               ss_n;
    logic                     i_mode_n;
    logic                     busy_n;
    logic                     ready_n;
    logic                     illegal_n;

    // instr_ready always equals !full, so this is a plain handshake.
    assign push    = instr_valid && instr_ready && !fifo_full;
    assign count_n = fifo_count + CNT_W'(push) - CNT_W'(pop);

    assign hd_op   = fifo_rdata[OPC_MSB:OPC_LSB];
    assign hd_addr = fifo_rdata[ADDR_MSB:ADDR_LSB];
    assign hd_data = fifo_rdata[DATA_MSB:DATA_LSB];
    assign hd_cnt  = fifo_rdata[CNT_MSB:CNT_LSB];

    // Instruction bits above the count field and head bits beyond the
    // configured address/data widths carry nothing the controller needs.
    assign instr_unused = ^instruction;
    assign head_unused  = ^{hd_addr, hd_data};

    sa_instr_fifo #(
        .WIDTH (FIELD_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .wdata (instruction[FIELD_W-1:0]),
        .pop   (pop),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // Sequencer next state: pop on idle or on the last beat so issue is gapless.
    always_comb begin
        last_beat   = (state_q == S_EXEC) && (beats_left == '0);
        pop         = !fifo_empty && ((state_q == S_IDLE) || last_beat);
        state_n     = state_q;
        op_n        = cur_op;
        addr_n      = cur_addr;
        data_n      = cur_data;
        beats_n     = beats_left;
        beat_addr_n = beat_addr;
        if (pop) begin
            state_n     = S_EXEC;
            op_n        = hd_op;
            addr_n      = hd_addr[ADDR_W-1:0];
            data_n      = hd_data[DATA_W-1:0];
            beats_n     = beats_minus_one(hd_op, hd_cnt, MAC_M1, ARR_M1);
            beat_addr_n = hd_addr[OUT_ADDR_W-1:0];
        end else if (last_beat) begin
            state_n = S_IDLE;
        end else if (state_q == S_EXEC) begin
            beats_n     = beats_left - 1'b1;
            beat_addr_n = beat_addr + 1'b1;
        end
    end

    // Sequencer registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            cur_op     <= OP_NOP;
            cur_addr   <= '0;
            cur_data   <= '0;
            beats_left <= '0;
            beat_addr  <= '0;
        end else begin
            state_q    <= state_n;
            cur_op     <= op_n;
            cur_addr   <= addr_n;
            cur_data   <= data_n;
            beats_left <= beats_n;
            beat_addr  <= beat_addr_n;
        end
    end

    // Decode the held beat into next output values; addresses/data and
    // i_mode hold unless the beat drives them.
    always_comb begin
        inp_we_n   = 1'b0;
        inp_addr_n = inp_buf_addr;
        inp_data_n = inp_buf_data;
        wt_we_n    = 1'b0;
        wt_addr_n  = wt_buf_addr;
        wt_data_n  = wt_buf_data;
        wt_send_n  = 1'b0;
        mac_en_n   = 1'b0;
        acc_n      = 1'b0;
        acc_addr_n = acc_to_op_buf_addr;
        tx_n       = 1'b0;
        out_addr_n = out_buf_addr;
        clr_n      = 1'b0;
        ss_n       = SS_IDLE;
        i_mode_n   = i_mode;
        illegal_n  = illegal_op;
        if (state_q == S_EXEC) begin
            case (cur_op)
                OP_NOP: begin
                end
                OP_MAC: begin
                    mac_en_n = 1'b1;
                    ss_n     = SS_COMPUTE;
                    i_mode_n = 1'b0;
                end
                OP_SEND_WT: begin
                    wt_send_n = 1'b1;
                    ss_n      = SS_LOAD;
                    i_mode_n  = 1'b1;
                end
                OP_STORE_OUT: begin
                    acc_n      = 1'b1;
                    acc_addr_n = beat_addr;
                    ss_n       = SS_DRAIN;
                end
                OP_RECV_INP: begin
                    inp_we_n   = 1'b1;
                    inp_addr_n = cur_addr;
                    inp_data_n = cur_data;
                end
                OP_RECV_WT: begin
                    wt_we_n   = 1'b1;
                    wt_addr_n = cur_addr;
                    wt_data_n = cur_data;
                end
                OP_TX_OUT: begin
                    tx_n       = 1'b1;
                    out_addr_n = beat_addr;
                    ss_n       = SS_DRAIN;
                end
                OP_RST_ACC: begin
                    clr_n = 1'b1;
                end
                default: begin
                    illegal_n = 1'b1;
                end
            endcase
        end
        // Busy covers queued work, a held beat, and a beat still being presented.
        busy_n  = (state_q == S_EXEC) || (state_n == S_EXEC) || (count_n != '0);
        ready_n = (count_n != CNT_W'(FIFO_DEPTH));
    end

    // Registered outputs; reset aborts any beat in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            instr_ready                     <= 1'b1;
            inp_buf_we                      <= 1'b0;
            inp_buf_addr                    <= '0;
            inp_buf_data                    <= '0;
            wt_buf_we                       <= 1'b0;
            wt_buf_addr                     <= '0;
            wt_buf_data                     <= '0;
            wt_send                         <= 1'b0;
            mac_en                          <= 1'b0;
            acc_result_to_op_buf            <= 1'b0;
            acc_to_op_buf_addr              <= '0;
            op_buffer_instr_for_sending_data <= 1'b0;
            out_buf_addr                    <= '0;
            instr_for_accum_to_reset        <= 1'b0;
            state_signal                    <= SS_IDLE;
            i_mode                          <= 1'b0;
            busy                            <= 1'b0;
            illegal_op                      <= 1'b0;
        end else begin
            instr_ready                     <= ready_n;
            inp_buf_we                      <= inp_we_n;
            inp_buf_addr                    <= inp_addr_n;
            inp_buf_data                    <= inp_data_n;
            wt_buf_we                       <= wt_we_n;
            wt_buf_addr                     <= wt_addr_n;
            wt_buf_data                     <= wt_data_n;
            wt_send                         <= wt_send_n;
            mac_en                          <= mac_en_n;
            acc_result_to_op_buf            <= acc_n;
            acc_to_op_buf_addr              <= acc_addr_n;
            op_buffer_instr_for_sending_data <= tx_n;
            out_buf_addr                    <= out_addr_n;
            instr_for_accum_to_reset        <= clr_n;
            state_signal                    <= ss_n;
            i_mode                          <= i_mode_n;
            busy                            <= busy_n;
            illegal_op                      <= illegal_n;
        end
    end

endmodule

// File: tb/tb_sa_controller_v2.sv
// Bench for sa_controller_v2: a schedule-based model expands each accepted
// instruction into timed beats and is compared against the DUT every cycle,
// alongside directed scenarios with literal expectations.
module tb_sa_controller_v2;

    localparam int INSTR_W    = 64;
    localparam int ADDR_W     = 14;
    localparam int DATA_W     = 32;
    localparam int OUT_ADDR_W = 4;
    localparam int ARRAY_N    = 4;
    localparam int MAC_CYCLES = 7;
    localparam int DEPTH      = 4;

    logic                  clk;
    logic                  rst;
    logic                  instr_valid;
    logic                  instr_ready;
    logic [INSTR_W-1:0]    instruction;
    logic                  inp_buf_we;
    logic [ADDR_W-1:0]     inp_buf_addr;
    logic [DATA_W-1:0]     inp_buf_data;
    logic                  wt_buf_we;
    logic [ADDR_W-1:0]     wt_buf_addr;
    logic [DATA_W-1:0]     wt_buf_data;
    logic                  wt_send;
    logic                  mac_en;
    logic                  acc_result_to_op_buf;
    logic [OUT_ADDR_W-1:0] acc_to_op_buf_addr;
    logic                  op_buffer_instr_for_sending_data;
    logic [OUT_ADDR_W-1:0] out_buf_addr;
    logic                  instr_for_accum_to_reset;
    logic [1:0]            state_signal;
    logic                  i_mode;
    logic                  busy;
    logic                  illegal_op;

    sa_controller_v2 #(
        .INSTR_W(INSTR_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .OUT_ADDR_W(OUT_ADDR_W),
        .ARRAY_N(ARRAY_N), .MAC_CYCLES(MAC_CYCLES), .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk(clk), .rst(rst), .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instruction(instruction),
        .inp_buf_we(inp_buf_we), .inp_buf_addr(inp_buf_addr), .inp_buf_data(inp_buf_data),
        .wt_buf_we(wt_buf_we), .wt_buf_addr(wt_buf_addr), .wt_buf_data(wt_buf_data),
        .wt_send(wt_send), .mac_en(mac_en),
        .acc_result_to_op_buf(acc_result_to_op_buf), .acc_to_op_buf_addr(acc_to_op_buf_addr),
        .op_buffer_instr_for_sending_data(op_buffer_instr_for_sending_data),
        .out_buf_addr(out_buf_addr), .instr_for_accum_to_reset(instr_for_accum_to_reset),
        .state_signal(state_signal), .i_mode(i_mode), .busy(busy), .illegal_op(illegal_op)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic timeout_fail(input string nm);
        n_checks++;
        n_fail++;
        $display("FAIL %s: bound expired", nm);
    endtask

    function automatic logic [63:0] mk(input logic [4:0] op, input logic [15:0] addr,
                                       input logic [31:0] data, input logic [7:0] cnt);
        return {3'b000, cnt, data, addr, op};
    endfunction

    // ---------------- model ----------------
    typedef struct {
        int          edge_no;
        logic [4:0]  op;
        logic [15:0] addr;
        logic [31:0] data;
    } beat_t;

    beat_t beats[$];
    int    pops[$];
    int    next_free = 0;
    bit    m_ready   = 1'b1;
    int    cyc       = 0;
    int    last_acc_cyc = -1;

    logic                  e_inp_we, e_wt_we, e_wt_send, e_mac, e_acc, e_tx, e_clr;
    logic [ADDR_W-1:0]     e_inp_addr, e_wt_addr;
    logic [DATA_W-1:0]     e_inp_data, e_wt_data;
    logic [OUT_ADDR_W-1:0] e_acc_addr, e_out_addr;
    logic [1:0]            e_ss;
    logic                  e_imode, e_busy, e_ready, e_illegal;

    task automatic accept(input logic [63:0] ins);
        beat_t       b;
        logic [4:0]  op;
        logic [15:0] addr;
        logic [31:0] data;
        logic [7:0]  cnt;
        int          n;
        int          start;
        op   = ins[4:0];
        addr = ins[20:5];
        data = ins[52:21];
        cnt  = ins[60:53];
        case (op)
            5'd1:       n = MAC_CYCLES;
            5'd2:       n = ARRAY_N;
            5'd3, 5'd6: n = int'(cnt) + 1;
            default:    n = 1;
        endcase
        start = (cyc + 2 > next_free) ? cyc + 2 : next_free;
        for (int k = 0; k < n; k++) begin
            b.edge_no = start + k;
            b.op      = op;
            b.addr    = addr + 16'(k);
            b.data    = data;
            beats.push_back(b);
        end
        pops.push_back(start - 1);
        next_free = start + n;
    endtask

    task automatic apply(input beat_t b);
        case (b.op)
            5'd0: ;
            5'd1: begin e_mac = 1'b1; e_ss = 2'b10; e_imode = 1'b0; end
            5'd2: begin e_wt_send = 1'b1; e_ss = 2'b01; e_imode = 1'b1; end
            5'd3: begin e_acc = 1'b1; e_acc_addr = b.addr[3:0]; e_ss = 2'b11; end
            5'd4: begin e_inp_we = 1'b1; e_inp_addr = b.addr[13:0]; e_inp_data = b.data; end
            5'd5: begin e_wt_we = 1'b1; e_wt_addr = b.addr[13:0]; e_wt_data = b.data; end
            5'd6: begin e_tx = 1'b1; e_out_addr = b.addr[3:0]; e_ss = 2'b11; end
            5'd7: e_clr = 1'b1;
            default: e_illegal = 1'b1;
        endcase
    endtask

    // monitor counters for the directed scenarios
    int inp_cnt, first_inp, ws_cnt, ws_last, mac_cnt, mac_first, st_cnt, tx_cnt;
    int clr_cnt, clr_cyc, ill_cyc, nrdy_cnt, wtwe_cnt;
    logic [31:0] inp_data_q[$];
    logic [3:0]  st_addr_q[$];

    task automatic clear_mon();
        inp_cnt = 0; first_inp = -1; ws_cnt = 0; ws_last = -1; mac_cnt = 0; mac_first = -1;
        st_cnt = 0; tx_cnt = 0; clr_cnt = 0; clr_cyc = -1; ill_cyc = -1; nrdy_cnt = 0;
        wtwe_cnt = 0;
        inp_data_q.delete();
        st_addr_q.delete();
    endtask

    // Model step and full comparison, one cycle after each rising edge.
    always @(posedge clk) begin
        #1;
        cyc++;
        if (rst) begin
            beats.delete();
            pops.delete();
            next_free = 0;
            m_ready = 1'b1;
            {e_inp_we, e_wt_we, e_wt_send, e_mac, e_acc, e_tx, e_clr} = '0;
            e_inp_addr = '0; e_wt_addr = '0; e_inp_data = '0; e_wt_data = '0;
            e_acc_addr = '0; e_out_addr = '0; e_ss = 2'b00;
            e_imode = 1'b0; e_busy = 1'b0; e_ready = 1'b1; e_illegal = 1'b0;
        end else begin
            if (instr_valid && m_ready) begin
                accept(instruction);
                last_acc_cyc = cyc;
            end
            {e_inp_we, e_wt_we, e_wt_send, e_mac, e_acc, e_tx, e_clr} = '0;
            e_ss = 2'b00;
            if (beats.size() > 0 && beats[0].edge_no == cyc) begin
                apply(beats.pop_front());
            end
            while (pops.size() > 0 && pops[0] <= cyc) void'(pops.pop_front());
            m_ready = (pops.size() < DEPTH);
            e_ready = m_ready;
            e_busy  = (next_free > cyc);
        end
        chk("instr_ready", instr_ready, e_ready);
        chk("busy", busy, e_busy);
        chk("inp_buf_we", inp_buf_we, e_inp_we);
        chk("inp_buf_addr", inp_buf_addr, e_inp_addr);
        chk("inp_buf_data", inp_buf_data, e_inp_data);
        chk("wt_buf_we", wt_buf_we, e_wt_we);
        chk("wt_buf_addr", wt_buf_addr, e_wt_addr);
        chk("wt_buf_data", wt_buf_data, e_wt_data);
        chk("wt_send", wt_send, e_wt_send);
        chk("mac_en", mac_en, e_mac);
        chk("acc_result_to_op_buf", acc_result_to_op_buf, e_acc);
        chk("acc_to_op_buf_addr", acc_to_op_buf_addr, e_acc_addr);
        chk("op_buffer_tx", op_buffer_instr_for_sending_data, e_tx);
        chk("out_buf_addr", out_buf_addr, e_out_addr);
        chk("accum_reset", instr_for_accum_to_reset, e_clr);
        chk("state_signal", state_signal, e_ss);
        chk("i_mode", i_mode, e_imode);
        chk("illegal_op", illegal_op, e_illegal);

        if (inp_buf_we === 1'b1) begin
            inp_cnt++;
            if (first_inp < 0) first_inp = cyc;
            inp_data_q.push_back(inp_buf_data);
        end
        if (wt_buf_we === 1'b1) wtwe_cnt++;
        if (wt_send === 1'b1) begin ws_cnt++; ws_last = cyc; end
        if (mac_en === 1'b1) begin
            mac_cnt++;
            if (mac_first < 0) mac_first = cyc;
        end
        if (acc_result_to_op_buf === 1'b1) begin
            st_cnt++;
            st_addr_q.push_back(acc_to_op_buf_addr);
        end
        if (op_buffer_instr_for_sending_data === 1'b1) tx_cnt++;
        if (instr_for_accum_to_reset === 1'b1) begin clr_cnt++; clr_cyc = cyc; end
        if (illegal_op === 1'b1 && ill_cyc < 0) ill_cyc = cyc;
        if (instr_ready === 1'b0) nrdy_cnt++;
    end

    // ---------------- stimulus helpers (called at a falling edge) ----------------
    task automatic send(input logic [63:0] ins);
        instruction = ins;
        instr_valid = 1'b1;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (last_acc_cyc == cyc) return;
        end
        timeout_fail("send_accept");
    endtask

    task automatic wait_idle(input int bound);
        instr_valid = 1'b0;
        for (int i = 0; i < bound; i++) begin
            @(negedge clk);
            if (!e_busy) return;
        end
        timeout_fail("wait_idle");
    endtask

    logic [3:0] exp_st [4];
    int         acc_a;

    initial begin
        rst = 1'b1;
        instr_valid = 1'b0;
        instruction = '0;
        clear_mon();
        repeat (3) @(negedge clk);
        chk("rst_instr_ready", instr_ready, 1'b1);
        chk("rst_busy", busy, 1'b0);
        chk("rst_state_signal", state_signal, 2'b00);
        rst = 1'b0;
        @(negedge clk);

        // single RECV_INP
        clear_mon();
        send(mk(5'd4, 16'h0001, 32'hDEADBEEF, 8'd0));
        acc_a = last_acc_cyc;
        wait_idle(50);
        chk("t1_we_count", 64'(inp_cnt), 64'd1);
        chk("t1_latency", 64'(first_inp - acc_a), 64'd2);
        chk("t1_addr", inp_buf_addr, 14'h0001);
        chk("t1_data", inp_buf_data, 32'hDEADBEEF);
        chk("t1_busy", busy, 1'b0);

        // SEND_WT followed by MAC
        clear_mon();
        send(mk(5'd2, 16'h0, 32'h0, 8'd0));
        send(mk(5'd1, 16'h0, 32'h0, 8'd0));
        wait_idle(60);
        chk("t2_wt_send_beats", 64'(ws_cnt), 64'd4);
        chk("t2_mac_beats", 64'(mac_cnt), 64'd7);
        chk("t2_no_gap", 64'(mac_first - ws_last), 64'd1);
        chk("t2_i_mode_after", i_mode, 1'b0);

        // STORE_OUT with address wrap
        clear_mon();
        send(mk(5'd3, 16'h000E, 32'h0, 8'd3));
        wait_idle(50);
        exp_st = '{4'hE, 4'hF, 4'h0, 4'h1};
        chk("t3_store_beats", 64'(st_cnt), 64'd4);
        for (int i = 0; i < 4; i++) begin
            if (i < st_addr_q.size()) chk("t3_store_addr", st_addr_q[i], exp_st[i]);
            else timeout_fail("t3_store_addr_missing");
        end
        chk("t3_state_idle", state_signal, 2'b00);

        // backpressure: MAC then five queued RECV_INP with valid held
        clear_mon();
        send(mk(5'd1, 16'h0, 32'h0, 8'd0));
        for (int i = 0; i < 5; i++) send(mk(5'd4, 16'(i), 32'h100 + 32'(i), 8'd0));
        wait_idle(80);
        chk("t4_not_ready_cycles", 64'(nrdy_cnt), 64'd4);
        chk("t4_inp_count", 64'(inp_cnt), 64'd5);
        for (int i = 0; i < 5; i++) begin
            if (i < inp_data_q.size()) chk("t4_order", inp_data_q[i], 32'h100 + 32'(i));
            else timeout_fail("t4_order_missing");
        end

        // illegal opcode then RST_ACC
        clear_mon();
        send(mk(5'h1F, 16'h0, 32'h0, 8'd0));
        send(mk(5'd7, 16'h0, 32'h0, 8'd0));
        wait_idle(50);
        repeat (4) @(negedge clk);
        chk("t5_illegal_sticky", illegal_op, 1'b1);
        chk("t5_clr_count", 64'(clr_cnt), 64'd1);
        chk("t5_clr_follows", 64'(clr_cyc - ill_cyc), 64'd1);

        // back-to-back RECV_WT, TX_OUT wrap, single-beat and 256-beat STORE_OUT
        clear_mon();
        send(mk(5'd5, 16'h3FFF, 32'hA5A5_0001, 8'd0));
        send(mk(5'd5, 16'h0010, 32'hA5A5_0002, 8'd0));
        send(mk(5'd5, 16'h0020, 32'hA5A5_0003, 8'd0));
        send(mk(5'd6, 16'h000F, 32'h0, 8'd2));
        send(mk(5'd3, 16'h0005, 32'h0, 8'd0));
        wait_idle(60);
        chk("t6_wt_we_count", 64'(wtwe_cnt), 64'd3);
        chk("t6_wt_data_hold", wt_buf_data, 32'hA5A5_0003);
        chk("t6_tx_beats", 64'(tx_cnt), 64'd3);
        chk("t6_out_addr_hold", out_buf_addr, 4'h1);
        chk("t6_store_single", 64'(st_cnt), 64'd1);
        clear_mon();
        send(mk(5'd3, 16'h0000, 32'h0, 8'd255));
        wait_idle(400);
        chk("t6_store_256", 64'(st_cnt), 64'd256);

        // reset during beat 3 of TX_OUT with two instructions queued
        clear_mon();
        send(mk(5'd6, 16'h0000, 32'h0, 8'd7));
        send(mk(5'd5, 16'h0042, 32'h1234_5678, 8'd0));
        send(mk(5'd0, 16'h0, 32'h0, 8'd0));
        instr_valid = 1'b0;
        for (int i = 0; i < 50 && tx_cnt < 4; i++) @(negedge clk);
        if (tx_cnt != 4) timeout_fail("t7_reach_beat3");
        rst = 1'b1;
        @(negedge clk);
        chk("t7_tx_off", op_buffer_instr_for_sending_data, 1'b0);
        chk("t7_busy", busy, 1'b0);
        chk("t7_ready", instr_ready, 1'b1);
        chk("t7_state", state_signal, 2'b00);
        chk("t7_out_addr", out_buf_addr, 4'h0);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        chk("t7_tx_total", 64'(tx_cnt), 64'd4);
        chk("t7_flushed", 64'(wtwe_cnt), 64'd0);
        chk("t7_busy_after", busy, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
